// File: rtl/mips_decode_execute.sv
// Single-cycle MIPS-I decode/execute with an internal 32x32 register file.
// Optional signed-overflow trapping on ADD/SUB/ADDI is enabled by defining OVERFLOW_TRAP_EN.
module mips_decode_execute #(
  parameter logic [31:0] SP_INIT = 32'h8010_0000,
  parameter logic [31:0] RA_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] instruction,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [31:0] out_val,
  output logic [31:0] out_pc,
  output logic        zero,
  output logic        br,
  output logic        jp,
  output logic        mem_op,
  output logic        mem_write,
  output logic        rwe,
  output logic [4:0]  rw_addr,
  output logic [31:0] store_data,
  output logic [31:0] link_val,
  output logic        nop,
  output logic        ovf
);

`ifdef OVERFLOW_TRAP_EN
  function automatic logic add_ovf(input logic signed [31:0] a, input logic signed [31:0] b,
                                   input logic signed [31:0] s);
    return (a[31] == b[31]) && (s[31] != a[31]);
  endfunction

  function automatic logic sub_ovf(input logic signed [31:0] a, input logic signed [31:0] b,
                                   input logic signed [31:0] d);
    return (a[31] != b[31]) && (d[31] != a[31]);
  endfunction
`endif

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  always_comb begin
    regs_d = regs_q;
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_d[i] = 32'h0;
      regs_d[29] = SP_INIT;
      regs_d[31] = RA_INIT;
    end else if (wb_en && wb_addr != 5'd0) begin
      regs_d[wb_addr] = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, sa;
  logic [31:0] rs_val, rt_val, imm_s, imm_z, pc_plus4, br_target, j_target;
  logic signed [31:0] rs_s, rt_s;
  logic signed [31:0] sum, diff, sumi;
  logic illegal;

  assign op    = instruction[31:26];
  assign rs    = instruction[25:21];
  assign rt    = instruction[20:16];
  assign rd    = instruction[15:11];
  assign sa    = instruction[10:6];
  assign funct = instruction[5:0];
  assign imm_s = {{16{instruction[15]}}, instruction[15:0]};
  assign imm_z = {16'h0, instruction[15:0]};

  // Register reads: r0 is hard zero, a pending writeback is forwarded.
  assign rs_val = (rs == 5'd0) ? 32'h0 : (wb_en && wb_addr == rs) ? wb_data : regs_q[rs];
  assign rt_val = (rt == 5'd0) ? 32'h0 : (wb_en && wb_addr == rt) ? wb_data : regs_q[rt];
  assign rs_s   = rs_val;
  assign rt_s   = rt_val;

  assign sum        = rs_s + rt_s;
  assign diff       = rs_s - rt_s;
  assign sumi       = rs_s + $signed(imm_s);
  assign pc_plus4   = pc + 32'd4;
  assign link_val   = pc + 32'd8;
  assign br_target  = pc_plus4 + {imm_s[29:0], 2'b00};
  assign j_target   = {pc_plus4[31:28], instruction[25:0], 2'b00};
  assign store_data = rt_val;

  always_comb begin
    out_val   = 32'h0;
    out_pc    = pc_plus4;
    zero      = 1'b0;
    br        = 1'b0;
    jp        = 1'b0;
    mem_op    = 1'b0;
    mem_write = 1'b0;
    rwe       = 1'b0;
    rw_addr   = 5'd0;
    nop       = 1'b0;
    ovf       = 1'b0;
    illegal   = 1'b0;
    case (op)
      6'h00: begin
        rwe     = 1'b1;
        rw_addr = rd;
        case (funct)
          6'h20: begin
            out_val = sum;
`ifdef OVERFLOW_TRAP_EN
            ovf = add_ovf(rs_s, rt_s, sum);
`endif
          end
          6'h21: out_val = sum;
          6'h22: begin
            out_val = diff;
`ifdef OVERFLOW_TRAP_EN
            ovf = sub_ovf(rs_s, rt_s, diff);
`endif
          end
          6'h23: out_val = diff;
          6'h24: out_val = rs_val & rt_val;
          6'h25: out_val = rs_val | rt_val;
          6'h26: out_val = rs_val ^ rt_val;
          6'h27: out_val = ~(rs_val | rt_val);
          6'h2A: out_val = {31'h0, rs_s < rt_s};
          6'h2B: out_val = {31'h0, rs_val < rt_val};
          6'h00: out_val = rt_val << sa;
          6'h02: out_val = rt_val >> sa;
          6'h03: out_val = rt_s >>> sa;
          6'h04: out_val = rt_val << rs_val[4:0];
          6'h06: out_val = rt_val >> rs_val[4:0];
          6'h07: out_val = rt_s >>> rs_val[4:0];
          6'h08: begin
            rwe     = 1'b0;
            rw_addr = 5'd0;
            jp      = 1'b1;
            out_val = rs_val;
            out_pc  = rs_val;
          end
          6'h09: begin
            jp      = 1'b1;
            out_val = rs_val;
            out_pc  = rs_val;
          end
          default: illegal = 1'b1;
        endcase
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        rwe     = 1'b1;
        rw_addr = rt;
        case (op)
          6'h08: begin
            out_val = sumi;
`ifdef OVERFLOW_TRAP_EN
            ovf = add_ovf(rs_s, $signed(imm_s), sumi);
`endif
          end
          6'h09:   out_val = sumi;
          6'h0A:   out_val = {31'h0, rs_s < $signed(imm_s)};
          6'h0B:   out_val = {31'h0, rs_val < imm_s};
          6'h0C:   out_val = rs_val & imm_z;
          6'h0D:   out_val = rs_val | imm_z;
          6'h0E:   out_val = rs_val ^ imm_z;
          default: out_val = {instruction[15:0], 16'h0};
        endcase
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        mem_op  = 1'b1;
        out_val = sumi;
        rwe     = 1'b1;
        rw_addr = rt;
      end
      6'h28, 6'h29, 6'h2B: begin
        mem_op    = 1'b1;
        mem_write = 1'b1;
        out_val   = sumi;
      end
      6'h04, 6'h05, 6'h06, 6'h07, 6'h01: begin
        br      = 1'b1;
        out_val = br_target;
        case (op)
          6'h04: zero = (rs_val == rt_val);
          6'h05: zero = (rs_val != rt_val);
          6'h06: zero = (rs_s <= 0);
          6'h07: zero = (rs_s > 0);
          default: begin
            if (rt == 5'd0)      zero = (rs_s < 0);
            else if (rt == 5'd1) zero = (rs_s >= 0);
            else                 illegal = 1'b1;
          end
        endcase
        out_pc = zero ? br_target : pc_plus4;
      end
      6'h02, 6'h03: begin
        jp      = 1'b1;
        out_val = j_target;
        out_pc  = j_target;
        if (op == 6'h03) begin
          rwe     = 1'b1;
          rw_addr = 5'd31;
        end
      end
      default: illegal = 1'b1;
    endcase

    // A trapped overflow keeps the wrapped result but suppresses the write.
    if (ovf) rwe = 1'b0;

    if (illegal || instruction == 32'h0) begin
      out_val   = 32'h0;
      out_pc    = pc_plus4;
      zero      = 1'b0;
      br        = 1'b0;
      jp        = 1'b0;
      mem_op    = 1'b0;
      mem_write = 1'b0;
      rwe       = 1'b0;
      rw_addr   = 5'd0;
      ovf       = 1'b0;
      nop       = 1'b1;
    end

    if (reset) begin
      out_val   = 32'h0;
      out_pc    = pc;
      zero      = 1'b0;
      br        = 1'b0;
      jp        = 1'b0;
      mem_op    = 1'b0;
      mem_write = 1'b0;
      rwe       = 1'b0;
      rw_addr   = 5'd0;
      ovf       = 1'b0;
      nop       = 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_decode_execute.sv
// Directed bench for mips_decode_execute with hand-computed expected values.
module tb_mips_decode_execute;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, instruction;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] out_val, out_pc, store_data, link_val;
  logic        zero, br, jp, mem_op, mem_write, rwe, nop, ovf;
  logic [4:0]  rw_addr;

  int checks = 0;
  int errors = 0;

  mips_decode_execute dut (
    .clk(clk), .reset(reset), .pc(pc), .instruction(instruction),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_val(out_val), .out_pc(out_pc), .zero(zero), .br(br), .jp(jp),
    .mem_op(mem_op), .mem_write(mem_write), .rwe(rwe), .rw_addr(rw_addr),
    .store_data(store_data), .link_val(link_val), .nop(nop), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    @(posedge clk);
    #1 wb_en = 1'b0;
  endtask

  task automatic apply(input logic [31:0] p, input logic [31:0] i);
    pc = p; instruction = i;
    #2;
  endtask

  initial begin
    reset = 1'b1; wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    pc = 32'h0000_0100; instruction = 32'h03A0_5021;
    @(posedge clk); #1;
    chk("rst_nop", {31'h0, nop}, 32'h1);
    chk("rst_out_pc", out_pc, 32'h0000_0100);
    chk("rst_out_val", out_val, 32'h0);
    chk("rst_rwe", {31'h0, rwe}, 32'h0);
    @(posedge clk); #1 reset = 1'b0;

    apply(32'h0000_0100, 32'h03A0_5021);   // ADDU r10,r29,r0
    chk("read_sp", out_val, 32'h8010_0000);
    chk("read_sp_rwe", {31'h0, rwe}, 32'h1);
    chk("read_sp_rd", {27'h0, rw_addr}, 32'd10);
    apply(32'h0000_0100, 32'h03E0_5021);   // ADDU r10,r31,r0
    chk("read_ra", out_val, 32'h0);
    apply(32'h0000_0100, 32'h0);
    chk("zero_nop", {31'h0, nop}, 32'h1);
    chk("zero_pc", out_pc, 32'h0000_0104);
    chk("zero_rwe", {31'h0, rwe}, 32'h0);

    wr(5'd8, 32'd5);
    apply(32'h8002_0000, 32'h2509_FFFF);   // ADDIU r9,r8,-1
    chk("addiu_val", out_val, 32'd4);
    chk("addiu_rwe", {31'h0, rwe}, 32'h1);
    chk("addiu_rd", {27'h0, rw_addr}, 32'd9);
    chk("addiu_pc", out_pc, 32'h8002_0004);

    wr(5'd4, 32'h8002_0100);
    apply(32'h8002_0000, 32'h8C82_FFFC);   // LW r2,-4(r4)
    chk("lw_memop", {31'h0, mem_op}, 32'h1);
    chk("lw_addr", out_val, 32'h8002_00FC);
    chk("lw_rwe", {31'h0, rwe}, 32'h1);
    chk("lw_rd", {27'h0, rw_addr}, 32'd2);
    apply(32'h8002_0000, 32'hAC88_0008);   // SW r8,8(r4)
    chk("sw_addr", out_val, 32'h8002_0108);
    chk("sw_mw", {31'h0, mem_write}, 32'h1);
    chk("sw_rwe", {31'h0, rwe}, 32'h0);
    chk("sw_data", store_data, 32'd5);

    wr(5'd8, 32'd3);
    wr(5'd9, 32'd3);
    apply(32'h8002_0010, 32'h1109_0004);   // BEQ r8,r9,+4
    chk("beq_br", {31'h0, br}, 32'h1);
    chk("beq_zero", {31'h0, zero}, 32'h1);
    chk("beq_val", out_val, 32'h8002_0024);
    chk("beq_pc", out_pc, 32'h8002_0024);
    wr(5'd9, 32'd2);
    apply(32'h8002_0010, 32'h1109_0004);
    chk("beqn_zero", {31'h0, zero}, 32'h0);
    chk("beqn_pc", out_pc, 32'h8002_0014);
    chk("beqn_val", out_val, 32'h8002_0024);
    wr(5'd10, 32'hFFFF_FFFF);
    apply(32'h8002_0010, 32'h0540_0001);   // BLTZ r10,+1
    chk("bltz_zero", {31'h0, zero}, 32'h1);
    chk("bltz_pc", out_pc, 32'h8002_0018);

    apply(32'h8002_0020, 32'h0C08_0010);   // JAL
    chk("jal_jp", {31'h0, jp}, 32'h1);
    chk("jal_pc", out_pc, 32'h8020_0040);
    chk("jal_link", link_val, 32'h8002_0028);
    chk("jal_rd", {27'h0, rw_addr}, 32'd31);
    chk("jal_rwe", {31'h0, rwe}, 32'h1);
    wr(5'd31, 32'h8002_0028);
    apply(32'h8020_0040, 32'h03E0_0008);   // JR r31
    chk("jr_pc", out_pc, 32'h8002_0028);
    chk("jr_jp", {31'h0, jp}, 32'h1);
    chk("jr_rwe", {31'h0, rwe}, 32'h0);

    wr(5'd8, 32'h7FFF_FFFF);
    apply(32'h8002_0000, 32'h0108_4820);   // ADD r9,r8,r8
    chk("add_val", out_val, 32'hFFFF_FFFE);
`ifdef OVERFLOW_TRAP_EN
    chk("add_ovf", {31'h0, ovf}, 32'h1);
    chk("add_rwe", {31'h0, rwe}, 32'h0);
`else
    chk("add_ovf", {31'h0, ovf}, 32'h0);
    chk("add_rwe", {31'h0, rwe}, 32'h1);
`endif

    wr(5'd9, 32'h8000_0000);
    apply(32'h8002_0000, 32'h0009_5103);   // SRA r10,r9,4
    chk("sra", out_val, 32'hF800_0000);
    apply(32'h8002_0000, 32'h0128_502A);   // SLT r10,r9,r8
    chk("slt", out_val, 32'h1);
    apply(32'h8002_0000, 32'h0128_502B);   // SLTU r10,r9,r8
    chk("sltu", out_val, 32'h0);
    apply(32'h8002_0000, 32'h3C0A_1234);   // LUI r10,0x1234
    chk("lui", out_val, 32'h1234_0000);
    apply(32'h8002_0000, 32'hFC00_0000);
    chk("illegal_nop", {31'h0, nop}, 32'h1);
    chk("illegal_val", out_val, 32'h0);

    wr(5'd0, 32'h0000_0123);
    apply(32'h8002_0000, 32'h0000_5021);   // ADDU r10,r0,r0
    chk("r0_write", out_val, 32'h0);

    @(negedge clk);
    wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'hDEAD_BEEF;
    apply(32'h8002_0000, 32'h0180_5021);   // ADDU r10,r12,r0
    chk("bypass", out_val, 32'hDEAD_BEEF);
    @(posedge clk); #1 wb_en = 1'b0;
    apply(32'h8002_0000, 32'h0180_5021);
    chk("bypass_stored", out_val, 32'hDEAD_BEEF);

    // Reset must win over a simultaneous write to r29.
    @(negedge clk);
    reset = 1'b1; wb_en = 1'b1; wb_addr = 5'd29; wb_data = 32'h1;
    @(posedge clk); #1 reset = 1'b0; wb_en = 1'b0;
    apply(32'h8002_0000, 32'h03A0_5021);
    chk("rst_prio_sp", out_val, 32'h8010_0000);
    apply(32'h8002_0000, 32'h0180_5021);
    chk("rst_clears_r12", out_val, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_decode_execute.md
Name: mips_decode_execute

Overview:
- Single-cycle MIPS-I decode plus execute block.
- Takes the fetched 32-bit instruction and its PC. Decodes fields and control, reads the internal 32x32 register file, and computes in the same cycle:
  - ALU result, or
  - load/store effective address, or
  - branch/jump target and next PC.
- Sits between instruction memory and data memory/writeback. Writeback data returns through the wb_* port.

Parameters:
- SP_INIT, 32'h8010_0000, reset value of register 29 ($sp); every other register resets to 0.
- RA_INIT, 32'h0000_0000, reset value of register 31.

Ports:
- clk  in  1  clock; register file writes on the rising edge.
- reset  in  1  synchronous, active-high.
- pc  in  32  address of the current instruction.
- instruction  in  32  current instruction word.
- wb_en  in  1  register file write enable.
- wb_addr  in  5  write register.
- wb_data  in  32  write data.
- out_val  out  32  ALU result / effective address / branch or jump target.
- out_pc  out  32  next PC.
- zero  out  1  branch taken (valid when br=1).
- br  out  1  conditional branch.
- jp  out  1  jump (J, JAL, JR, JALR).
- mem_op  out  1  load or store.
- mem_write  out  1  store.
- rwe  out  1  instruction writes a register.
- rw_addr  out  5  destination: rd (R-type), rt (I-type), 31 (JAL).
- store_data  out  32  rt value for stores.
- link_val  out  32  pc+8, written on JAL/JALR.
- nop  out  1  no-op or unsupported instruction.
- ovf  out  1  signed overflow (see Optional Feature).

Behaviour:
- Decode and execute are purely combinational from instruction, pc and register reads. Latency is 0 cycles.
- Register file:
  - 32x32; r0 reads 0 and ignores writes.
  - Write on rising clk when wb_en && wb_addr!=0.
  - Read ports bypass: if wb_en and wb_addr matches the read register, the read returns wb_data.
  - Synchronous reset sets all registers to 0, except r29=SP_INIT and r31=RA_INIT. Reset has priority over a same-edge write.
- While reset is high: nop=1; rwe=br=jp=mem_op=mem_write=zero=ovf=0; out_val=0; out_pc=pc.
- instruction==32'h0000_0000, or any unsupported opcode/funct: nop=1, rwe=0, all control 0, out_val=0, out_pc=pc+4.
- R-type (op 0x00), by funct:
  - ADD 20, ADDU 21, SUB 22, SUBU 23: 32-bit wrap arithmetic.
  - AND 24, OR 25, XOR 26, NOR 27.
  - SLT 2A (signed compare), SLTU 2B (unsigned compare).
  - SLL 00, SRL 02, SRA 03: shift amount from sa.
  - SLLV 04, SRLV 06, SRAV 07: shift amount is rs[4:0].
  - JR 08, JALR 09.
- I-type:
  - ADDI 08, ADDIU 09, SLTI 0A, SLTIU 0B: immediate sign-extended.
  - ANDI 0C, ORI 0D, XORI 0E: immediate zero-extended.
  - LUI 0F: {imm,16'h0}.
- Memory ops: LB 20, LH 21, LW 23, LBU 24, LHU 25, SB 28, SH 29, SW 2B.
  - mem_op=1; out_val = rs + sext(imm).
  - Loads: rwe=1. Stores: mem_write=1, rwe=0.
- Branches: BEQ 04, BNE 05, BLEZ 06, BGTZ 07, REGIMM 01 with rt=0 BLTZ, rt=1 BGEZ.
  - br=1; out_val = pc+4+(sext(imm)<<2); zero = condition.
  - out_pc = zero ? out_val : pc+4. All compares are signed.
- Jumps: J 02, JAL 03, JR, JALR.
  - jp=1; out_pc = out_val = target.
  - J/JAL target = {pc_plus4[31:28], instr_index, 2'b00}; JR/JALR target = rs.
  - JAL writes 31; JALR writes rd. The written value is link_val.
- All other instructions: out_pc = pc+4. There is no delay-slot modelling beyond target arithmetic.
- pc+4 and target arithmetic wrap modulo 2^32.

Optional Feature:
- Macro OVERFLOW_TRAP_EN.
- Defined: ADD, SUB and ADDI detect signed overflow. On overflow, ovf=1 and rwe is forced to 0; out_val still carries the wrapped result.
- Undefined: ADD/SUB/ADDI behave as ADDU/SUBU/ADDIU, and ovf is tied to 0.

Test Plan:
- Reset, then read: after reset the register file holds r29=32'h8010_0000 and all other registers 0. Read r29 via ADDU rd,r29,r0 → out_val=8010_0000; instruction 0 → nop=1, out_pc=pc+4.
- ADDIU: wb r8=5; pc=8002_0000, instruction 2509_FFFF (ADDIU r9,r8,-1) → out_val=4, rwe=1, rw_addr=9, out_pc=8002_0004.
- Load: wb r4=8002_0100; LW r2,-4(r4) (8C82_FFFC) → mem_op=1, out_val=8002_00FC, rwe=1.
- Branch: r8=3, r9=3, pc=8002_0010, BEQ r8,r9,+4 (1109_0004) → br=1, zero=1, out_val=out_pc=8002_0024. With r9=2 → zero=0, out_pc=8002_0014.
- Jump: pc=8002_0020, JAL 0x0008_0010 (0C08_0010) → jp=1, out_pc=8020_0040, link_val=8002_0028, rw_addr=31. JR r31 → out_pc=r31.
- Overflow: r8=7FFF_FFFF, ADD r9,r8,r8 → with OVERFLOW_TRAP_EN: ovf=1, rwe=0. Without it: out_val=FFFF_FFFE, rwe=1. Also cover write-to-r0 ignored and same-cycle write/read bypass.
